// File: rtl/deser_pkg.sv
// Shared types and elaboration helpers for the deser_word_rx receiver.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    // Number of beats needed to fill one word.
    function automatic int unsigned beats(input int unsigned word_w, input int unsigned lanes);
        return word_w / lanes;
    endfunction

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/deser_word_rx_fifo.sv
// Small synchronous word FIFO with registered full/empty flags and a level count.
module deser_fifo #(
    parameter int unsigned W     = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // Qualify requests against the flags and compute the next fill level.
    always_comb begin
        do_push = push_i & ~full_q;
        do_pop  = pop_i & ~empty_q;
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (do_pop && !do_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage, wrapping pointers and flags registered from the next level.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/deser_word_rx.sv
// Multi-lane serial-to-parallel word receiver with an output word FIFO.
// Optional feature: define DESER_PARITY_EN to take a trailing even-parity beat
// per word and report a per-word parity error on word_err_o.
module deser_word_rx
    import deser_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LANES      = 1,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable_i,
    input  logic                          bit_valid_i,
    input  logic [LANES-1:0]              bit_in_i,
    output logic                          bit_ready_o,
    output logic                          word_valid_o,
    output logic [WORD_W-1:0]             word_data_o,
    output logic                          word_err_o,
    input  logic                          word_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned BEATS = beats(WORD_W, LANES);
    localparam int unsigned CNT_W = $clog2(BEATS + 1);
    localparam int unsigned FW    = WORD_W + 1;

    // Reject configurations the datapath cannot represent.
    if ((WORD_W % LANES) != 0) begin : g_bad_lanes
        $error("deser_word_rx: WORD_W must be a multiple of LANES");
    end
    if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_bad_depth
        $error("deser_word_rx: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] acc_q;
    logic [WORD_W-1:0] acc_shift;
    logic              last_beat;
    logic              accept;
    logic              push;
    logic [FW-1:0]     push_data;
    logic [FW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;

    // Accumulator with the current beat folded in, in the configured bit order.
    if (BEATS == 1) begin : g_shift_one
        assign acc_shift = bit_in_i;
    end else if (MSB_FIRST) begin : g_shift_msb
        assign acc_shift = {acc_q[WORD_W-LANES-1:0], bit_in_i};
    end else begin : g_shift_lsb
        assign acc_shift = {bit_in_i, acc_q[WORD_W-1:LANES]};
    end

    // Beat acceptance and FIFO write request for the completing beat.
    always_comb begin
        accept    = enable_i & bit_valid_i & ~fifo_full;
        last_beat = (cnt_q == CNT_W'(BEATS - 1));
`ifdef DESER_PARITY_EN
        push      = accept & (state_q == PARITY);
        push_data = {(^acc_q) ^ bit_in_i[0], acc_q};
`else
        push      = accept & last_beat;
        push_data = {1'b0, acc_shift};
`endif
    end

    // Receive FSM, beat counter and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (!enable_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (accept) begin
            case (state_q)
                IDLE, SHIFT: begin
                    if (last_beat) begin
`ifdef DESER_PARITY_EN
                        state_q <= PARITY;
                        cnt_q   <= CNT_W'(BEATS);
                        acc_q   <= acc_shift;
`else
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        acc_q   <= '0;
`endif
                    end else begin
                        state_q <= SHIFT;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        acc_q   <= acc_shift;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                end
            endcase
        end
    end

    deser_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (word_ready_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    assign bit_ready_o  = ~fifo_full;
    assign word_valid_o = ~fifo_empty;
    assign word_data_o  = fifo_head[WORD_W-1:0];

`ifdef DESER_PARITY_EN
    assign word_err_o = fifo_head[WORD_W];
`else
    logic unused_err;
    assign unused_err = fifo_head[WORD_W];
    assign word_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_deser_word_rx.sv
// Directed bench for deser_word_rx: a 1-lane MSB-first instance and a 4-lane LSB-first instance.
module tb_deser_word_rx;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        bit_valid;
    logic [0:0]  bit_in;
    logic        bit_ready;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_err;
    logic        word_ready;
    logic [1:0]  fifo_level;

    logic        en4;
    logic        v4;
    logic [3:0]  in4;
    logic        rdy4;
    logic        wv4;
    logic [31:0] wd4;
    logic        we4;
    logic        wr4;
    logic [1:0]  lvl4;

    int tests_run;
    int tests_failed;

    deser_word_rx #(.WORD_W(32), .LANES(1), .FIFO_DEPTH(2), .MSB_FIRST(1'b1)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .bit_valid_i  (bit_valid),
        .bit_in_i     (bit_in),
        .bit_ready_o  (bit_ready),
        .word_valid_o (word_valid),
        .word_data_o  (word_data),
        .word_err_o   (word_err),
        .word_ready_i (word_ready),
        .fifo_level_o (fifo_level)
    );

    deser_word_rx #(.WORD_W(32), .LANES(4), .FIFO_DEPTH(2), .MSB_FIRST(1'b0)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (en4),
        .bit_valid_i  (v4),
        .bit_in_i     (in4),
        .bit_ready_o  (rdy4),
        .word_valid_o (wv4),
        .word_data_o  (wd4),
        .word_err_o   (we4),
        .word_ready_i (wr4),
        .fifo_level_o (lvl4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic beat1(input logic b);
        int guard;
        guard = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        while (bit_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL beat1_timeout: bit_ready=%b want 1", bit_ready);
        end else begin
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
    endtask

    task automatic beat4(input logic [3:0] n);
        int guard;
        guard = 0;
        v4  = 1'b1;
        in4 = n;
        while (rdy4 !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            tests_run++; tests_failed++;
            $display("FAIL beat4_timeout: rdy4=%b want 1", rdy4);
        end else begin
            @(posedge clk); #1;
        end
        v4 = 1'b0;
    endtask

    task automatic bits1(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) beat1(w[31-i]);
    endtask

    task automatic word1(input logic [31:0] w);
        bits1(w, 32);
`ifdef DESER_PARITY_EN
        beat1(^w);
`endif
    endtask

    task automatic pop1();
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %b want 0", word_valid); end
        tests_run++;
        if (fifo_level !== 2'd0) begin tests_failed++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
        tests_run++;
        if (word_data !== 32'h0) begin tests_failed++; $display("FAIL rst_data: got %h want 0", word_data); end
        tests_run++;
        if (word_err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", word_err); end
        tests_run++;
        if (bit_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", bit_ready); end
        tests_run++;
        if (lvl4 !== 2'd0 || wv4 !== 1'b0) begin tests_failed++; $display("FAIL rst_dut4: lvl=%0d valid=%b want 0/0", lvl4, wv4); end
    endtask

    task automatic test_msb_first();
        word_ready = 1'b1;
        bits1(32'hDEADBEEF, 31);
        tests_run++;
        if (word_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_valid_early: got %b want 0", word_valid); end
        beat1(1'b1);
`ifdef DESER_PARITY_EN
        beat1(^32'hDEADBEEF);
`endif
        tests_run++;
        if (word_valid !== 1'b1) begin tests_failed++; $display("FAIL t1_valid: got %b want 1", word_valid); end
        tests_run++;
        if (word_data !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL t1_data: got %h want deadbeef", word_data); end
        tests_run++;
        if (fifo_level !== 2'd1) begin tests_failed++; $display("FAIL t1_level: got %0d want 1", fifo_level); end
        tests_run++;
        if (word_err !== 1'b0) begin tests_failed++; $display("FAIL t1_err: got %b want 0", word_err); end
        @(posedge clk); #1;
        word_ready = 1'b0;
        tests_run++;
        if (fifo_level !== 2'd0 || word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t1_popped: level=%0d valid=%b want 0/0", fifo_level, word_valid);
        end
    endtask

    task automatic test_lanes4_lsb_first();
        logic [3:0] nibs [8];
        nibs = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
        en4 = 1'b1;
        wr4 = 1'b0;
        for (int i = 0; i < 8; i++) beat4(nibs[i]);
`ifdef DESER_PARITY_EN
        beat4(4'h0);
`endif
        tests_run++;
        if (wv4 !== 1'b1 || wd4 !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL t2_word: valid=%b data=%h want 1/deadbeef", wv4, wd4);
        end
        tests_run++;
        if (lvl4 !== 2'd1 || we4 !== 1'b0) begin
            tests_failed++; $display("FAIL t2_level_err: lvl=%0d err=%b want 1/0", lvl4, we4);
        end
        wr4 = 1'b1;
        @(posedge clk); #1;
        wr4 = 1'b0;
        tests_run++;
        if (lvl4 !== 2'd0) begin tests_failed++; $display("FAIL t2_pop: lvl=%0d want 0", lvl4); end
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        word1(32'hA5A5_0001);
        word1(32'h5A5A_0002);
        tests_run++;
        if (bit_ready !== 1'b0 || fifo_level !== 2'd2) begin
            tests_failed++; $display("FAIL t3_full: ready=%b level=%0d want 0/2", bit_ready, fifo_level);
        end
        bit_valid = 1'b1; bit_in = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bit_valid = 1'b0;
        tests_run++;
        if (fifo_level !== 2'd2 || word_data !== 32'hA5A5_0001) begin
            tests_failed++; $display("FAIL t3_hold: level=%0d data=%h want 2/a5a50001", fifo_level, word_data);
        end
        word_ready = 1'b1;
        tests_run++;
        if (bit_ready !== 1'b0) begin tests_failed++; $display("FAIL t3_ready_pop_cycle: got %b want 0", bit_ready); end
        @(posedge clk); #1;
        word_ready = 1'b0;
        tests_run++;
        if (bit_ready !== 1'b1 || fifo_level !== 2'd1 || word_data !== 32'h5A5A_0002) begin
            tests_failed++; $display("FAIL t3_after_pop: ready=%b level=%0d data=%h want 1/1/5a5a0002", bit_ready, fifo_level, word_data);
        end
        word1(32'h3C3C_0003);
        tests_run++;
        if (fifo_level !== 2'd2 || bit_ready !== 1'b0) begin
            tests_failed++; $display("FAIL t3_third: level=%0d ready=%b want 2/0", fifo_level, bit_ready);
        end
        pop1();
        tests_run++;
        if (word_data !== 32'h3C3C_0003 || fifo_level !== 2'd1) begin
            tests_failed++; $display("FAIL t3_order: data=%h level=%0d want 3c3c0003/1", word_data, fifo_level);
        end
        pop1();
        tests_run++;
        if (fifo_level !== 2'd0 || word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t3_drain: level=%0d valid=%b want 0/0", fifo_level, word_valid);
        end
    endtask

    task automatic test_enable_abort();
        word_ready = 1'b0;
        bits1(32'hFFFF_FFFF, 17);
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        word1(32'h1234_5678);
        tests_run++;
        if (fifo_level !== 2'd1 || word_data !== 32'h1234_5678) begin
            tests_failed++; $display("FAIL t4_abort: level=%0d data=%h want 1/12345678", fifo_level, word_data);
        end
        pop1();
        // Completing beat arrives in the same cycle enable falls: discarded.
        bits1(32'hFFFF_FFFF, 31);
`ifdef DESER_PARITY_EN
        beat1(1'b1);
`endif
        enable = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0; enable = 1'b1;
        tests_run++;
        if (fifo_level !== 2'd0 || word_valid !== 1'b0) begin
            tests_failed++; $display("FAIL t4_last_beat_drop: level=%0d valid=%b want 0/0", fifo_level, word_valid);
        end
        word1(32'h0000_00C3);
        tests_run++;
        if (word_data !== 32'h0000_00C3 || fifo_level !== 2'd1) begin
            tests_failed++; $display("FAIL t4_clean_word: data=%h level=%0d want 000000c3/1", word_data, fifo_level);
        end
        pop1();
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b0;
        word1(32'h1111_2222);
        bits1(32'h3333_4445, 31);
`ifdef DESER_PARITY_EN
        beat1(1'b1);
        word_ready = 1'b1;
        beat1(^32'h3333_4445);
`else
        word_ready = 1'b1;
        beat1(1'b1);
`endif
        word_ready = 1'b0;
        tests_run++;
        if (fifo_level !== 2'd1 || word_data !== 32'h3333_4445) begin
            tests_failed++; $display("FAIL b2b_push_pop: level=%0d data=%h want 1/33334445", fifo_level, word_data);
        end
        pop1();
    endtask

    task automatic test_reset_mid_word();
        word_ready = 1'b0;
        word1(32'hCAFE_F00D);
        bits1(32'hFFFF_FFFF, 10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if (word_valid !== 1'b0 || fifo_level !== 2'd0 || bit_ready !== 1'b1) begin
            tests_failed++; $display("FAIL t5_reset: valid=%b level=%0d ready=%b want 0/0/1", word_valid, fifo_level, bit_ready);
        end
        word1(32'h0F0F_1234);
        tests_run++;
        if (word_data !== 32'h0F0F_1234 || fifo_level !== 2'd1) begin
            tests_failed++; $display("FAIL t5_next_word: data=%h level=%0d want 0f0f1234/1", word_data, fifo_level);
        end
        pop1();
    endtask

`ifdef DESER_PARITY_EN
    task automatic test_parity();
        word_ready = 1'b0;
        bits1(32'h0000_0001, 32);
        beat1(1'b0);
        tests_run++;
        if (word_err !== 1'b1 || word_data !== 32'h1) begin
            tests_failed++; $display("FAIL t6_bad_parity: err=%b data=%h want 1/00000001", word_err, word_data);
        end
        pop1();
        bits1(32'h0000_0001, 32);
        beat1(1'b1);
        tests_run++;
        if (word_err !== 1'b0 || word_valid !== 1'b1) begin
            tests_failed++; $display("FAIL t6_good_parity: err=%b valid=%b want 0/1", word_err, word_valid);
        end
        pop1();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset      = 1'b1;
        enable     = 1'b1;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        word_ready = 1'b0;
        en4        = 1'b0;
        v4         = 1'b0;
        in4        = 4'h0;
        wr4        = 1'b0;

        test_reset();
        test_msb_first();
        test_lanes4_lsb_first();
        test_backpressure();
        test_enable_abort();
        test_back_to_back();
        test_reset_mid_word();
`ifdef DESER_PARITY_EN
        test_parity();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
